// File: rtl/cpu_run_monitor_pkg.sv
// Shared definitions for the tinycpu run-time monitor: opcode, FSM encoding, trace entry layout.
package cpu_run_monitor_pkg;

    localparam logic [1:0] OPC_JMP = 2'b11;

    typedef enum logic [0:0] {
        MON_RUN    = 1'b0,
        MON_HALTED = 1'b1
    } mon_state_e;

    // Trace entry is {A,B,M,P}; offsets are in units of DATA_W, P in the low slot.
    localparam int TRACE_A_OFS = 3;
    localparam int TRACE_B_OFS = 2;
    localparam int TRACE_M_OFS = 1;
    localparam int TRACE_P_OFS = 0;

endpackage

// File: rtl/cpu_run_monitor_fifo.sv
// mon_trace_fifo: count-based synchronous FWFT FIFO with a same-cycle pop-and-push when full
// and a sticky flag for dropped pushes.
module mon_trace_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             overflow_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             full_s, pop_s, push_ok_s;

    assign full_s    = (cnt_q == (AW+1)'(DEPTH));
    assign valid_o   = (cnt_q != '0);
    assign pop_s     = valid_o & ready_i;
    assign push_ok_s = push_i & (~full_s | pop_s);
    assign data_o    = mem_q[rd_q];
    assign overflow_o = ovf_q;

    // Pointer, occupancy and overflow next-state; clear wins over any same-cycle traffic.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_d = wr_q + AW'(1);
            end else begin
                wr_d = wr_q;
            end
            if (pop_s) begin
                rd_d = rd_q + AW'(1);
            end else begin
                rd_d = rd_q;
            end
            case ({push_ok_s, pop_s})
                2'b10:   cnt_d = cnt_q + (AW+1)'(1);
                2'b01:   cnt_d = cnt_q - (AW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
            if (push_i & ~push_ok_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_ok_s && !clear) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: halt-loop detector and instruction/cycle counters for tinycpu.
// Trace FIFO of {A,B,M,P} IDLE snapshots is built only when CPU_MON_TRACE_EN is defined.
module cpu_run_monitor
    import cpu_run_monitor_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int LOOP_THRESH = 1,
    parameter int CNT_W       = 32,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                exec_valid,
    input  logic [1:0]          exec_opcode,
    input  logic                idle_valid,
    input  logic [DATA_W-1:0]   reg_a,
    input  logic [DATA_W-1:0]   reg_b,
    input  logic [DATA_W-1:0]   reg_m,
    input  logic [DATA_W-1:0]   reg_p,
    output logic                halted,
    output logic [CNT_W-1:0]    instr_count,
    output logic [CNT_W-1:0]    cycle_count,
    output logic                trace_valid,
    input  logic                trace_ready,
    output logic [4*DATA_W-1:0] trace_data,
    output logic                trace_overflow
);

    mon_state_e        state_q, state_d;
    logic [7:0]        loop_q, loop_d;
    logic [CNT_W-1:0]  instr_q, instr_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [DATA_W-1:0] p_minus_s;
    logic              self_jump_s;
    logic [8:0]        loop_inc_s;
    logic              reach_s;

    // P has already advanced past the JMP, so a jump to itself targets P-1 (mod 2^DATA_W).
    assign p_minus_s   = reg_p - DATA_W'(1);
    assign self_jump_s = exec_valid & (exec_opcode == OPC_JMP) & (p_minus_s == reg_m);
    assign loop_inc_s  = {1'b0, loop_q} + 9'd1;
    assign reach_s     = (loop_inc_s >= 9'(LOOP_THRESH));

    // FSM next state, loop counter and run counters.
    always_comb begin
        state_d = state_q;
        loop_d  = loop_q;
        instr_d = instr_q;
        cycle_d = cycle_q;
        if (clear) begin
            state_d = MON_RUN;
            loop_d  = 8'd0;
            instr_d = '0;
            cycle_d = '0;
        end else begin
            case (state_q)
                MON_RUN: begin
                    cycle_d = cycle_q + CNT_W'(1);
                    if (exec_valid) begin
                        instr_d = instr_q + CNT_W'(1);
                    end else begin
                        instr_d = instr_q;
                    end
                    if (self_jump_s) begin
                        if (reach_s) begin
                            state_d = MON_HALTED;
                            loop_d  = 8'(LOOP_THRESH);
                        end else begin
                            state_d = MON_RUN;
                            loop_d  = loop_inc_s[7:0];
                        end
                    end else if (exec_valid) begin
                        loop_d = 8'd0;
                    end else begin
                        loop_d = loop_q;
                    end
                end
                MON_HALTED: begin
                    state_d = MON_HALTED;
                end
                default: begin
                    state_d = MON_RUN;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MON_RUN;
            loop_q  <= 8'd0;
            instr_q <= '0;
            cycle_q <= '0;
        end else begin
            state_q <= state_d;
            loop_q  <= loop_d;
            instr_q <= instr_d;
            cycle_q <= cycle_d;
        end
    end

    assign halted      = (state_q == MON_HALTED);
    assign instr_count = instr_q;
    assign cycle_count = cycle_q;

`ifdef CPU_MON_TRACE_EN
    logic [4*DATA_W-1:0] snap_s;

    assign snap_s[TRACE_A_OFS*DATA_W +: DATA_W] = reg_a;
    assign snap_s[TRACE_B_OFS*DATA_W +: DATA_W] = reg_b;
    assign snap_s[TRACE_M_OFS*DATA_W +: DATA_W] = reg_m;
    assign snap_s[TRACE_P_OFS*DATA_W +: DATA_W] = reg_p;

    mon_trace_fifo #(
        .WIDTH (4*DATA_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .push_i     (idle_valid & (state_q == MON_RUN)),
        .data_i     (snap_s),
        .ready_i    (trace_ready),
        .valid_o    (trace_valid),
        .data_o     (trace_data),
        .overflow_o (trace_overflow)
    );
`else
    logic unused_trace_s;

    assign unused_trace_s = ^{trace_ready, idle_valid, reg_a, reg_b};
    assign trace_valid    = 1'b0;
    assign trace_data     = '0;
    assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor (THRESH=3 and THRESH=1 instances) plus a standalone trace FIFO.
module tb_cpu_run_monitor;

`ifdef CPU_MON_TRACE_EN
    localparam bit TE = 1'b1;
`else
    localparam bit TE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, clear, exec_valid, idle_valid, trace_ready;
    logic [1:0]  exec_opcode;
    logic [7:0]  reg_a, reg_b, reg_m, reg_p;

    logic        h3, h1, tv3, tv1, to3, to1;
    logic [31:0] ic3, ic1, cc3, cc1, td3, td1;
    logic        f_valid, f_ovf;
    logic [7:0]  f_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_run_monitor #(.DATA_W(8), .LOOP_THRESH(3), .CNT_W(32), .TRACE_DEPTH(4)) dut3 (
        .clk(clk), .reset(reset), .clear(clear), .exec_valid(exec_valid),
        .exec_opcode(exec_opcode), .idle_valid(idle_valid),
        .reg_a(reg_a), .reg_b(reg_b), .reg_m(reg_m), .reg_p(reg_p),
        .halted(h3), .instr_count(ic3), .cycle_count(cc3),
        .trace_valid(tv3), .trace_ready(trace_ready), .trace_data(td3),
        .trace_overflow(to3)
    );

    cpu_run_monitor #(.DATA_W(8), .LOOP_THRESH(1), .CNT_W(32), .TRACE_DEPTH(8)) dut1 (
        .clk(clk), .reset(reset), .clear(clear), .exec_valid(exec_valid),
        .exec_opcode(exec_opcode), .idle_valid(idle_valid),
        .reg_a(reg_a), .reg_b(reg_b), .reg_m(reg_m), .reg_p(reg_p),
        .halted(h1), .instr_count(ic1), .cycle_count(cc1),
        .trace_valid(tv1), .trace_ready(trace_ready), .trace_data(td1),
        .trace_overflow(to1)
    );

    mon_trace_fifo #(.WIDTH(8), .DEPTH(4)) u_fifo (
        .clk(clk), .reset(reset), .clear(clear), .push_i(idle_valid),
        .data_i(reg_a), .ready_i(trace_ready), .valid_o(f_valid),
        .data_o(f_data), .overflow_o(f_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] snap(input logic [7:0] a);
        return TE ? {a, 8'h22, 8'h33, 8'h44} : 32'h0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; clear = 1'b0; exec_valid = 1'b0; exec_opcode = 2'b00;
        idle_valid = 1'b0; trace_ready = 1'b0;
        reg_a = 8'h00; reg_b = 8'h00; reg_m = 8'h00; reg_p = 8'h00;
        tick(); tick();
        chk("rst_halted", h3, 1'b0);
        chk("rst_instr", ic3, 32'd0);
        chk("rst_cycle", cc3, 32'd0);
        chk("rst_tvalid", tv3, 1'b0);
        chk("rst_fvalid", f_valid, 1'b0);
        reset = 1'b1;

        // 1: five non-jump execs
        exec_valid = 1'b1; exec_opcode = 2'b00;
        for (int i = 0; i < 5; i++) tick();
        exec_valid = 1'b0;
        chk("t1_instr", ic3, 32'd5);
        chk("t1_cycle", cc3, 32'd5);
        chk("t1_halted", h3, 1'b0);
        tick();
        chk("t1_cycle_idle", cc3, 32'd6);
        chk("t1_instr_idle", ic3, 32'd5);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_instr", ic3, 32'd0);
        chk("clr_cycle", cc3, 32'd0);

        // 2: three consecutive self-jumps, THRESH=3
        reg_p = 8'h11; reg_m = 8'h10; exec_valid = 1'b1; exec_opcode = 2'b11;
        tick();
        chk("t2_h3_after1", h3, 1'b0);
        chk("t2_h1_after1", h1, 1'b1);
        chk("t2_ic1_frozen", ic1, 32'd1);
        tick();
        chk("t2_h3_after2", h3, 1'b0);
        tick();
        chk("t2_h3_after3", h3, 1'b1);
        chk("t2_instr", ic3, 32'd3);
        chk("t2_cycle", cc3, 32'd3);
        exec_opcode = 2'b00;
        for (int i = 0; i < 3; i++) tick();
        exec_valid = 1'b0;
        chk("t2_instr_frozen", ic3, 32'd3);
        chk("t2_cycle_frozen", cc3, 32'd3);
        chk("t2_still_halted", h3, 1'b1);
        chk("t2_ic1_still", ic1, 32'd1);
        chk("t2_cc1_still", cc1, 32'd1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t2_clr_halt", h3, 1'b0);

        // 3: jump, plain, jump, jump -> no halt; one more jump -> halt
        exec_valid = 1'b1;
        exec_opcode = 2'b11; tick();
        exec_opcode = 2'b00; tick();
        exec_opcode = 2'b11; tick(); tick();
        chk("t3_no_halt", h3, 1'b0);
        chk("t3_instr", ic3, 32'd4);
        tick();
        exec_valid = 1'b0;
        chk("t3_halt_on_third", h3, 1'b1);
        chk("t3_instr_final", ic3, 32'd5);
        clear = 1'b1; tick(); clear = 1'b0;

        // 3b: P-1 wrap at THRESH=1
        reg_p = 8'h00; reg_m = 8'h00; exec_valid = 1'b1; exec_opcode = 2'b11;
        tick();
        chk("t3_nomatch", h1, 1'b0);
        reg_m = 8'hFF; exec_opcode = 2'b10;
        tick();
        chk("t3_not_jmp", h1, 1'b0);
        exec_opcode = 2'b11;
        tick();
        exec_valid = 1'b0;
        chk("t3_wrap_halt", h1, 1'b1);
        clear = 1'b1; tick(); clear = 1'b0;

        // 4: six snapshots into depth 4 with no consumer
        reg_b = 8'h22; reg_m = 8'h33; reg_p = 8'h44; idle_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            reg_a = 8'(k);
            if (k == 1) chk("t4_valid_latency", f_valid, 1'b0);
            tick();
            if (k == 1) chk("t4_valid_rise", f_valid, 1'b1);
        end
        idle_valid = 1'b0;
        chk("t4_ovf", f_ovf, 1'b1);
        chk("t4_top_ovf", to3, TE);
        trace_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("t4_drain_valid", f_valid, 1'b1);
            chk("t4_drain_data", f_data, 8'(k));
            chk("t4_top_data", td3, snap(8'(k)));
            tick();
        end
        trace_ready = 1'b0;
        chk("t4_empty", f_valid, 1'b0);
        chk("t4_top_empty", tv3, 1'b0);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t4_clr_ovf", f_ovf, 1'b0);

        // 5: full FIFO, push and pop in the same cycle
        idle_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            reg_a = 8'(k); tick();
        end
        reg_a = 8'd5; trace_ready = 1'b1; tick();
        idle_valid = 1'b0;
        chk("t5_ovf", f_ovf, 1'b0);
        chk("t5_top_ovf", to3, 1'b0);
        for (int k = 2; k <= 5; k++) begin
            chk("t5_drain_valid", f_valid, 1'b1);
            chk("t5_drain_data", f_data, 8'(k));
            chk("t5_top_data", td3, snap(8'(k)));
            tick();
        end
        trace_ready = 1'b0;
        chk("t5_empty", f_valid, 1'b0);

        // 6: clear while halted with two queued entries
        idle_valid = 1'b1; reg_a = 8'h61; tick(); reg_a = 8'h62; tick();
        idle_valid = 1'b0;
        reg_p = 8'h44; reg_m = 8'h43; exec_valid = 1'b1; exec_opcode = 2'b11;
        tick(); tick(); tick();
        exec_valid = 1'b0;
        chk("t6_halted", h3, 1'b1);
        chk("t6_top_valid", tv3, TE);
        chk("t6_fvalid", f_valid, 1'b1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t6_clr_halt", h3, 1'b0);
        chk("t6_clr_instr", ic3, 32'd0);
        chk("t6_clr_cycle", cc3, 32'd0);
        chk("t6_clr_tvalid", tv3, 1'b0);
        chk("t6_clr_fvalid", f_valid, 1'b0);

        // 6b: asynchronous reset mid-drain
        reg_p = 8'h44; reg_m = 8'h33;
        exec_valid = 1'b1; exec_opcode = 2'b00; idle_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            reg_a = 8'(k); tick();
        end
        exec_valid = 1'b0; idle_valid = 1'b0; trace_ready = 1'b1;
        tick();
        chk("t6_mid_data", f_data, 8'd2);
        chk("t6_mid_cycle", cc3, 32'd4);
        #3 reset = 1'b0;
        #1;
        chk("t6_arst_instr", ic3, 32'd0);
        chk("t6_arst_cycle", cc3, 32'd0);
        chk("t6_arst_tvalid", tv3, 1'b0);
        chk("t6_arst_fvalid", f_valid, 1'b0);
        chk("t6_arst_halted", h3, 1'b0);
        trace_ready = 1'b0;
        reset = 1'b1;
        tick();
        chk("t6_post_fvalid", f_valid, 1'b0);
        chk("t6_post_cycle", cc3, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
